// File: rtl/mem_pkg.sv
// Shared types for the memory responder.
//   mem_size_e : access width encoding carried on req_size (3 is illegal)
//   state_e    : responder FSM states
//   mem_req_t  : request fields captured at acceptance
//   nbytes()   : byte count for a legal size
//   extend()   : zero/sign extension of an assembled load result
package mem_pkg;

    typedef enum logic [1:0] {
        BITS8  = 2'd0,
        BITS16 = 2'd1,
        BITS32 = 2'd2
    } mem_size_e;

    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic [2:0] nbytes(logic [1:0] size);
        logic [2:0] n;
        case (size)
            BITS8:   n = 3'd1;
            BITS16:  n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] extend(logic [31:0] raw, logic [1:0] size, logic uns);
        logic [31:0] res;
        case (size)
            BITS8:   res = {{24{~uns & raw[7]}}, raw[7:0]};
            BITS16:  res = {{16{~uns & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and mem_responder (slave).
//   req_*  : valid/ready request channel (write, size, unsigned, addr, wdata)
//   resp_* : valid/ready response channel (rdata, error)
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/byte_ram.sv
// Single-port byte storage: synchronous write, combinational read. Contents are
// not reset.
//   clk   : clock
//   we    : write enable for this cycle
//   addr  : byte address
//   wdata : byte to write
//   rdata : byte currently stored at addr
module byte_ram #(
    parameter int DEPTH_BYTES = 65536
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_BYTES)-1:0] addr,
    input  logic [7:0]                     wdata,
    output logic [7:0]                     rdata
);
    logic [7:0] mem [DEPTH_BYTES];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// Byte-serial memory responder. Accepts one load/store at a time, walks the
// access one byte per cycle (little-endian, wrapping at DEPTH_BYTES) and
// returns an extended load result or an error for an illegal size.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of mem_responder_if
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 65536
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_BYTES);

    state_e      state;
    mem_req_t    cap;
    logic [1:0]  cnt;
    logic [31:0] acc;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;
    logic [31:0]   merged;
    logic          last;

    always_comb begin
        // Truncating the full sum gives the modulo-DEPTH wrap for free.
        ram_addr  = AW'(cap.addr + 32'(cnt));
        ram_we    = (state == ACCESS) && cap.write;
        ram_wdata = cap.wdata[{cnt, 3'b000} +: 8];
        merged    = acc;
        merged[{cnt, 3'b000} +: 8] = ram_rdata;
        last      = ({1'b0, cnt} == nbytes(cap.size) - 3'd1);
    end

    byte_ram #(.DEPTH_BYTES(DEPTH_BYTES)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cap            <= '0;
            cnt            <= '0;
            acc            <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_error <= 1'b0;
            bus.resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        cap.write     <= bus.req_write;
                        cap.size      <= bus.req_size;
                        cap.uns       <= bus.req_unsigned;
                        cap.addr      <= bus.req_addr;
                        cap.wdata     <= bus.req_wdata;
                        cnt           <= '0;
                        acc           <= '0;
                        bus.req_ready <= 1'b0;
                        state         <= (bus.req_size == SIZE_ILLEGAL) ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    acc <= merged;
                    if (last) begin
                        state          <= RESP;
                        cnt            <= '0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= cap.write ? 32'h0 : extend(merged, cap.size, cap.uns);
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                RESP: begin
                    // Only the illegal-size path enters RESP with valid low; it
                    // raises valid one edge later so its latency matches BITS8.
                    if (!bus.resp_valid) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_error <= 1'b1;
                    end else if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.resp_error <= 1'b0;
                        bus.resp_rdata <= '0;
                        bus.req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    import mem_pkg::*;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if bus();

    mem_responder #(.DEPTH_BYTES(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    logic [7:0] mem_m [DEPTH];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         hold_cnt = 0;
    bit         in_resp = 0;
    bit         abort_busy = 0;
    bit         busy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_idx(logic [31:0] addr, int k);
        logic [31:0] a;
        a = addr + 32'(k);
        return int'(a % DEPTH);
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] addr, int n, bit uns);
        longint v;
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(mem_m[model_idx(addr, k)]) << (8 * k);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // Response-side backpressure: forced low for hold_cnt valid cycles, else random.
    always @(posedge clk) begin
        #1;
        if (hold_cnt > 0) begin
            bus.resp_ready = 1'b0;
            if (bus.resp_valid) hold_cnt--;
        end else begin
            bus.resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            busy = (q.size() != 0) || in_resp || abort_busy;
            chk("req_ready", {31'b0, bus.req_ready}, {31'b0, !busy});
            if (bus.resp_valid) begin
                if (!in_resp) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_resp: got resp_valid=1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        cur = q.pop_front();
                        in_resp = 1;
                        chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    end
                end
                if (in_resp) begin
                    chk("resp_rdata", bus.resp_rdata, cur.rdata);
                    chk("resp_error", {31'b0, bus.resp_error}, {31'b0, cur.err});
                    if (bus.resp_ready) in_resp = 0;
                end
            end else begin
                chk("idle_rdata", bus.resp_rdata, 32'h0);
                chk("idle_error", {31'b0, bus.resp_error}, 32'h0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
    task automatic do_req(bit wr, logic [1:0] size, bit uns, logic [31:0] addr, logic [31:0] wdata);
        exp_t e;
        int   n;
        int   waited;
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        waited = 0;
        while (!bus.req_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!bus.req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 200 cycles");
            bus.req_valid = 1'b0;
            return;
        end
        n = (size == BITS8) ? 1 : (size == BITS16) ? 2 : 4;
        e.acc = cyc + 1;
        if (size == 2'd3) begin
            e.rdata = 0; e.err = 1; e.lat = 1;
        end else begin
            e.err = 0;
            e.lat = n;
            if (wr) begin
                e.rdata = 0;
                for (int k = 0; k < n; k++) mem_m[model_idx(addr, k)] = 8'((wdata >> (8 * k)) & 32'hFF);
            end else begin
                e.rdata = model_load(addr, n, uns);
            end
        end
        @(posedge clk);
        #1;
        q.push_back(e);
        // Scramble the request fields: they must be ignored after capture.
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while ((q.size() != 0 || in_resp || !bus.req_ready) && waited < 500) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 500) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy expected idle within 500 cycles");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.resp_ready   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        chk("rst_resp_error", {31'b0, bus.resp_error}, 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        rst = 1'b0;
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'h1);

        // Fill the whole memory so the model knows every byte.
        for (int a = 0; a < DEPTH / 4; a++) do_req(1, BITS32, 0, 32'(a * 4), $urandom);

        // Word store/load round trip plus byte-level view.
        do_req(1, BITS32, 0, 32'h100, 32'hDEADBEEF);
        do_req(0, BITS32, 0, 32'h100, 32'h0);
        for (int k = 0; k < 4; k++) do_req(0, BITS8, 1, 32'(32'h100 + k), 32'h0);

        // Byte sign/zero extension.
        do_req(1, BITS8, 0, 32'h80, 32'hFFFF_FF85);
        do_req(0, BITS8, 0, 32'h80, 32'h0);
        do_req(0, BITS8, 1, 32'h80, 32'h0);

        // Half store wrapping across the top of memory.
        do_req(1, BITS16, 0, 32'(DEPTH - 1), 32'h0000_A1B2);
        do_req(0, BITS16, 0, 32'(DEPTH - 1), 32'h0);
        do_req(0, BITS8, 1, 32'(DEPTH - 1), 32'h0);
        do_req(0, BITS8, 1, 32'h0, 32'h0);

        // Illegal size: error response, memory untouched.
        do_req(1, 2'd3, 0, 32'h10, 32'h12345678);
        do_req(0, 2'd3, 1, 32'h10, 32'h0);
        do_req(0, BITS32, 0, 32'h10, 32'h0);

        // Held response; the next request is presented while RESP is stalled.
        wait_idle();
        hold_cnt = 5;
        do_req(0, BITS32, 0, 32'h100, 32'h0);
        do_req(0, BITS8, 0, 32'h80, 32'h0);

        // Reset during a word store after two bytes have been written.
        wait_idle();
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b1;
        bus.req_size     = BITS32;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h40;
        bus.req_wdata    = 32'h11223344;
        @(posedge clk);
        #1;
        abort_busy    = 1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        abort_busy = 0;
        mem_m[32'h40] = 8'h44;
        mem_m[32'h41] = 8'h33;
        #1;
        chk("abort_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        chk("abort_req_ready", {31'b0, bus.req_ready}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_post_req_ready", {31'b0, bus.req_ready}, 32'h1);
        chk("abort_post_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        do_req(0, BITS32, 1, 32'h40, 32'h0);
        for (int k = 0; k < 4; k++) do_req(0, BITS8, 1, 32'(32'h40 + k), 32'h0);

        // Random traffic, full 32-bit addresses so upper bits must be ignored.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) hold_cnt = $urandom_range(1, 4);
            do_req(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
        end

        wait_idle();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_BYTES, default 65536, size of the internal byte-addressed memory; power of two.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  initiator presents a request.
REQ-005 req_ready  out  1  responder accepts a request this cycle.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  MemSize: BITS8=0, BITS16=1, BITS32=2, 3 = illegal.
REQ-008 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  in  32  byte address, little-endian, any alignment.
REQ-010 req_wdata  in  32  store data; low N bytes used.
REQ-011 resp_valid  out  1  response available.
REQ-012 resp_ready  in  1  initiator consumes the response.
REQ-013 resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 resp_error  out  1  request had illegal req_size.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-017 On acceptance, write, size, unsigned flag, address and wdata SHALL be captured; request inputs are ignored afterwards.
REQ-018 N = 1, 2, 4 bytes for BITS8, BITS16, BITS32.
REQ-019 Legal request: IDLE -> ACCESS; ACCESS lasts exactly N cycles, one byte per cycle, byte index k = 0..N-1.
REQ-020 Byte k SHALL address (captured_addr + k) mod DEPTH_BYTES; upper address bits are ignored and crossing the top wraps to 0.
REQ-021 Store: byte k of memory receives wdata[8k+7:8k] on the ACCESS edge for index k.
REQ-022 Load: the read byte k is placed into the result at bits [8k+7:8k].
REQ-023 After the Nth ACCESS cycle: -> RESP; resp_valid rises N edges after the acceptance edge.
REQ-024 Load result: bits above 8N filled with the top result bit when req_unsigned=0, else zeros.
REQ-025 Illegal size: IDLE -> RESP directly; resp_error=1, resp_rdata=0, no memory change; resp_valid one edge after acceptance.
REQ-026 In RESP, resp_valid, resp_rdata and resp_error SHALL be held stable until resp_ready=1; that edge -> IDLE.
REQ-027 req_valid together with resp_ready in RESP SHALL NOT be accepted; the earliest next acceptance is in the following IDLE cycle.
REQ-028 Outside RESP: resp_valid=0, resp_error=0, resp_rdata=0.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, req_ready=1 after release, resp_valid=0, resp_error=0, resp_rdata=0, and clear the byte counter.
REQ-030 Memory contents SHALL NOT be cleared by reset; a store aborted mid-ACCESS keeps bytes already written and writes no further bytes.

Structure
REQ-031 MemSize enum and the FSM state enum SHALL live in shared package mem_pkg.
REQ-032 Byte storage SHALL be sub-module byte_ram: one byte port, synchronous write, combinational read, parameter DEPTH_BYTES.

Verification
REQ-033 Store word 0xDEADBEEF at 0x100 then load word from 0x100 -> bytes 0x100..0x103 = EF BE AD DE; rdata 0xDEADBEEF, resp_valid 4 edges after acceptance.
REQ-034 Memory byte 0x80 = 0x85: signed BITS8 load -> 0xFFFFFF85; unsigned -> 0x00000085; resp_valid 1 edge after acceptance.
REQ-035 Store half 0xA1B2 at DEPTH_BYTES-1 -> byte DEPTH-1 = B2, byte 0 = A1; a signed half load from the same address returns 0xFFFFA1B2.
REQ-036 req_size=3 store of 0x12345678 to 0x10 -> resp_error=1, rdata 0, memory at 0x10 unchanged.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0; new req_valid is not accepted until the cycle after resp_ready.
REQ-038 Assert rst after the 2nd ACCESS cycle of a word store of 0x11223344 at 0x40 -> bytes 0x40=44 and 0x41=33 written, 0x42/0x43 unchanged; FSM IDLE with resp_valid=0.
